// File: rtl/decoder_hold_pkg.sv
// Shared types and widths for the hold-and-decode block.
package decoder_hold_pkg;

    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;
    localparam int CNT_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Binary index to one-hot word; a disabled decode yields all zeros.
    function automatic logic [OUT_W-1:0] onehot(input logic en, input logic [CODE_W-1:0] code);
        return en ? (OUT_W'(1) << code) : '0;
    endfunction

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter that reports when it has reached zero.
module hold_counter
    import decoder_hold_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/decoder_hold.sv
// Decodes an accepted 3-bit code to a one-hot byte and holds it for HOLD_CYC cycles.
// Optional even-parity check on the input enabled by DECODER_HOLD_PARITY_EN.
module decoder_hold
    import decoder_hold_pkg::*;
#(
    parameter int HOLD_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_en,
    output logic [OUT_W-1:0]  y,
    output logic              y_valid,
    output logic              done
`ifdef DECODER_HOLD_PARITY_EN
    ,
    input  logic              in_par,
    output logic              par_err
`endif
);

    state_e           state_q, state_d;
    logic [OUT_W-1:0] y_q, y_d;
    logic             cnt_zero;
    logic             cnt_load;
    logic             cnt_dec;
    logic             accept;
    logic             par_ok;
    logic             take;

    hold_counter u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (CNT_W'(HOLD_CYC - 1)),
        .zero_o     (cnt_zero)
    );

    assign in_ready = (state_q == IDLE) || cnt_zero;
    assign accept   = in_valid && in_ready;

`ifdef DECODER_HOLD_PARITY_EN
    logic par_err_q;

    assign par_ok = (in_par == ^{in_en, in_code});

    // Sticky until reset: a bad-parity transfer completes its handshake but is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            par_err_q <= 1'b0;
        else if (accept && !par_ok)
            par_err_q <= 1'b1;
    end

    assign par_err = par_err_q;
`else
    assign par_ok = 1'b1;
`endif

    assign take = accept && par_ok;

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (take) begin
            state_d  = HOLD;
            y_d      = onehot(in_en, in_code);
            cnt_load = 1'b1;
        end else if (state_q == HOLD) begin
            if (cnt_zero) begin
                state_d = IDLE;
                y_d     = '0;
            end else begin
                cnt_dec = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    assign y       = y_q;
    assign y_valid = (state_q == HOLD);
    assign done    = (state_q == HOLD) && cnt_zero;

endmodule

// File: doc/decoder_hold.md
DECODER_HOLD -- requirements
Module: decoder_hold

Interface
REQ-001 SHALL have parameter HOLD_CYC, default 4, meaning the number of clock cycles each decoded word is held on y (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_code/in_en are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a code this cycle.
REQ-006 SHALL have port in_code, input, 3 bits: binary index to decode.
REQ-007 SHALL have port in_en, input, 1 bit: decode enable; 0 yields an all-zero word.
REQ-008 SHALL have port y, output, 8 bits: registered one-hot decoded word.
REQ-009 SHALL have port y_valid, output, 1 bit: y holds a decoded word.
REQ-010 SHALL have port done, output, 1 bit: single-cycle pulse in the last hold cycle of each word.

Function
REQ-011 SHALL implement states IDLE and HOLD only.
REQ-012 In IDLE, in_ready SHALL be 1; y=0, y_valid=0.
REQ-013 SHALL accept a transfer when in_valid && in_ready at a rising edge.
REQ-014 On acceptance the block SHALL, in the next cycle, drive y = in_en ? (8'b1 << in_code) : 8'h00, set y_valid=1, enter HOLD, and load hold counter = HOLD_CYC-1 (latency exactly 1 cycle).
REQ-015 In HOLD, the counter SHALL decrement by 1 per cycle; y and y_valid stay constant.
REQ-016 done SHALL be 1 exactly in the HOLD cycle where counter==0.
REQ-017 In HOLD, in_ready SHALL be 1 only when counter==0; otherwise in_valid is ignored and in_code is not sampled.
REQ-018 Back-to-back: acceptance while counter==0 SHALL load the new word and reload the counter with no idle gap (y_valid stays 1).
REQ-019 No acceptance while counter==0 SHALL return to IDLE next cycle, with y=0 and y_valid=0.
REQ-020 HOLD_CYC=1 SHALL give done=1 and in_ready=1 in every HOLD cycle (one word per cycle sustained).
REQ-021 y SHALL be one-hot or zero at all times; a word with in_en=0 still occupies HOLD_CYC cycles with y_valid=1.

Reset
REQ-022 Asserting rst SHALL immediately force state=IDLE, counter=0, y=0, y_valid=0, done=0, and in_ready=1 once rst deasserts.
REQ-023 Reset in mid-HOLD SHALL abandon the current word without a done pulse.
REQ-024 The first acceptance is possible on the first rising edge after rst deasserts.

Configuration
REQ-025 Macro DECODER_HOLD_PARITY_EN SHALL, when defined, add input in_par (1 bit) and output par_err (1 bit, sticky).
REQ-026 With the macro defined, a transfer where in_par != ^{in_en,in_code} (even parity) SHALL be accepted (handshake completes) but discarded: no state change, y unaffected, par_err set to 1 until rst.
REQ-027 Without the macro, in_par and par_err SHALL NOT exist, and every accepted transfer is decoded.

Structure
REQ-028 Package decoder_hold_pkg SHALL hold the state enum (IDLE, HOLD), CODE_W=3, OUT_W=8, and the counter width CNT_W=8.
REQ-029 The down-counter SHALL be a sub-module hold_counter (load, decrement, zero flag); decode and FSM stay in decoder_hold.

Verification
REQ-030 Reset mid-HOLD: accept code 5, assert rst 2 cycles later -> y=0, y_valid=0 immediately, no done pulse.
REQ-031 Single word, HOLD_CYC=4: in_code=3, in_en=1 -> y=8'b0000_1000 for 4 cycles, done in the 4th, then y=0 and y_valid=0.
REQ-032 Back-to-back: code 7 then code 0 offered at counter==0 -> y goes 8'h80 then 8'h01 with no gap, in_ready low during the first 3 HOLD cycles.
REQ-033 Disabled decode: in_en=0, in_code=6 -> y=8'h00, y_valid=1 for HOLD_CYC cycles, done pulses.
REQ-034 HOLD_CYC=1 sweep: codes 0..7 on consecutive cycles -> y walks 8'h01..8'h80, done high each cycle.
REQ-035 With DECODER_HOLD_PARITY_EN: in_code=1, in_en=1, in_par=1 -> word dropped, state stays IDLE, par_err=1 and remains set; a correct-parity code 2 then decodes to 8'h04.
